// File: rtl/normalize_pack_float64_front.sv
// Float64 normalization front end: left-justifies zSig so bit 62 holds the
// leading one, compensating zExp, using a coarse 8-bit then fine 1-bit scan.
module normalize_pack_float64_front (
    input  logic        ap_clk,
    input  logic        ap_rst,
    input  logic        ap_start,
    output logic        ap_done,
    output logic        ap_idle,
    output logic        ap_ready,
    input  logic        zSign,
    input  logic [11:0] zExp,
    input  logic [63:0] zSig,
    output logic        zSign_o,
    output logic [11:0] zExp_o,
    output logic [63:0] zSig_o
);

    typedef enum logic [3:0] {
        IDLE   = 4'b0001,
        COARSE = 4'b0010,
        FINE   = 4'b0100,
        OUT    = 4'b1000
    } state_t;

    state_t             state;
    state_t             state_n;
    logic        [63:0] sig_r;
    logic        [63:0] sig_n;
    logic        [11:0] exp_r;
    logic        [11:0] exp_n;
    logic               sign_r;
    logic               sign_n;
    logic signed [6:0]  sc;
    logic signed [6:0]  sc_n;
    logic               load;
    logic        [11:0] exp_adj;

    always_comb begin
        state_n = state;
        sig_n   = sig_r;
        exp_n   = exp_r;
        sign_n  = sign_r;
        sc_n    = sc;
        load    = 1'b0;
        case (state)
            IDLE: begin
                if (ap_start) begin
                    sig_n   = zSig;
                    exp_n   = zExp;
                    sign_n  = zSign;
                    sc_n    = 7'sd0;
                    state_n = COARSE;
                end
            end
            COARSE: begin
                if (sig_r[63]) begin
                    // Right shift by one, jamming the lost bit into bit 0
                    sig_n   = {1'b0, sig_r[63:1]} | {63'd0, sig_r[0]};
                    sc_n    = -7'sd1;
                    state_n = OUT;
                    load    = 1'b1;
                end else if (sig_r[62:55] == 8'd0 && sc <= 7'sd55) begin
                    sig_n = {sig_r[55:0], 8'd0};
                    sc_n  = sc + 7'sd8;
                end else begin
                    state_n = FINE;
                end
            end
            FINE: begin
                if (!sig_r[62] && sc < 7'sd63) begin
                    sig_n = {sig_r[62:0], 1'b0};
                    sc_n  = sc + 7'sd1;
                end else begin
                    state_n = OUT;
                    load    = 1'b1;
                end
            end
            OUT: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    assign exp_adj = exp_n - {{5{sc_n[6]}}, sc_n};

    // Result registers load on the edge entering OUT so they are valid with ap_done
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state   <= IDLE;
            sig_r   <= 64'd0;
            exp_r   <= 12'd0;
            sign_r  <= 1'b0;
            sc      <= 7'sd0;
            zSig_o  <= 64'd0;
            zExp_o  <= 12'd0;
            zSign_o <= 1'b0;
        end else begin
            state  <= state_n;
            sig_r  <= sig_n;
            exp_r  <= exp_n;
            sign_r <= sign_n;
            sc     <= sc_n;
            if (load) begin
                zSig_o  <= sig_n;
                zExp_o  <= exp_adj;
                zSign_o <= sign_n;
            end
        end
    end

    assign ap_idle  = (state == IDLE) & ~ap_start;
    assign ap_ready = (state == OUT);
    assign ap_done  = (state == OUT) | ((state == IDLE) & ~ap_start);

endmodule

// File: tb/tb_normalize_pack_float64_front.sv
// Self-checking bench for normalize_pack_float64_front: vector table,
// reset and back-to-back sequences, and random vectors vs a clz-based model.
module tb_normalize_pack_float64_front;

    logic        ap_clk = 1'b0;
    logic        ap_rst;
    logic        ap_start;
    logic        ap_done;
    logic        ap_idle;
    logic        ap_ready;
    logic        zSign;
    logic [11:0] zExp;
    logic [63:0] zSig;
    logic        zSign_o;
    logic [11:0] zExp_o;
    logic [63:0] zSig_o;

    int tests = 0;
    int failed = 0;

    always #5 ap_clk = ~ap_clk;

    normalize_pack_float64_front dut (
        .ap_clk(ap_clk), .ap_rst(ap_rst), .ap_start(ap_start),
        .ap_done(ap_done), .ap_idle(ap_idle), .ap_ready(ap_ready),
        .zSign(zSign), .zExp(zExp), .zSig(zSig),
        .zSign_o(zSign_o), .zExp_o(zExp_o), .zSig_o(zSig_o)
    );

    typedef struct {
        logic [63:0] sig;
        logic [11:0] exp;
        logic        sign;
        logic [63:0] e_sig;
        logic [11:0] e_exp;
        int          e_lat;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] got,
                       input logic [63:0] want);
        tests++;
        if (got !== want) begin
            failed++;
            $display("FAIL %s: got %h, want %h", name, got, want);
        end
    endtask

    // Reference: shiftCount = clz64(sig) - 1, latency from shift split
    function automatic void model(input logic [63:0] s, input logic [11:0] e,
                                  output logic [63:0] os, output logic [11:0] oe,
                                  output int lat);
        int z;
        int shc;
        int coarse;
        if (s[63]) begin
            os  = (s >> 1) | {63'd0, s[0]};
            oe  = e + 12'd1;
            lat = 2;
        end else begin
            z = 64;
            for (int i = 63; i >= 0; i--) begin
                if (s[i]) begin
                    z = 63 - i;
                    break;
                end
            end
            shc    = z - 1;
            os     = s << shc;
            oe     = e - 12'(shc);
            coarse = (shc / 8 > 7) ? 7 : shc / 8;
            lat    = 3 + coarse + (shc - 8 * coarse);
        end
    endfunction

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge ap_clk);
        while (!ap_idle && n < 50) begin
            @(negedge ap_clk);
            n++;
        end
        if (!ap_idle) begin
            tests++;
            failed++;
            $display("FAIL wait_idle: got busy, want idle");
        end
    endtask

    // Issue one request; returns the cycle ap_ready rose, -1 on timeout
    task automatic run(input logic [63:0] s, input logic [11:0] e,
                       input logic sg, output int lat);
        wait_idle();
        zSig = s;
        zExp = e;
        zSign = sg;
        ap_start = 1'b1;
        @(posedge ap_clk);
        #1;
        ap_start = 1'b0;
        lat = -1;
        for (int c = 1; c <= 40; c++) begin
            if (c > 1) begin
                @(posedge ap_clk);
                #1;
            end
            zSig = {$urandom, $urandom};
            zExp = 12'($urandom);
            if (ap_ready) begin
                lat = c;
                break;
            end
        end
    endtask

    task automatic check_vec(input string name, input vec_t v);
        int lat;
        run(v.sig, v.exp, v.sign, lat);
        chk({name, " lat"}, 64'(lat), 64'(v.e_lat));
        chk({name, " done"}, 64'(ap_done), 64'd1);
        chk({name, " sig"}, zSig_o, v.e_sig);
        chk({name, " exp"}, 64'(zExp_o), 64'(v.e_exp));
        chk({name, " sign"}, 64'(zSign_o), 64'(v.sign));
    endtask

    vec_t tbl[6];
    vec_t v;
    int   lat;
    int   lat2;
    logic [63:0] es;
    logic [11:0] ee;
    logic [63:0] es2;
    logic [11:0] ee2;
    int   el;
    int   el2;
    logic seen;

    initial begin
        tbl[0] = '{64'h4000_0000_0000_0000, 12'h3FF, 1'b1,
                   64'h4000_0000_0000_0000, 12'h3FF, 3};
        tbl[1] = '{64'h1, 12'd100, 1'b0,
                   64'h4000_0000_0000_0000, 12'd38, 16};
        tbl[2] = '{64'h0, 12'd10, 1'b1, 64'h0, 12'hFCB, 17};
        tbl[3] = '{64'h8000_0000_0000_0001, 12'h3FE, 1'b0,
                   64'h4000_0000_0000_0001, 12'h3FF, 2};
        tbl[4] = '{64'hC000_0000_0000_0000, 12'hFFF, 1'b0,
                   64'h6000_0000_0000_0000, 12'h000, 2};
        tbl[5] = '{64'h0000_0000_0100_0000, 12'h400, 1'b1,
                   64'h4000_0000_0000_0000, 12'h3DA, 13};

        ap_rst = 1'b1;
        ap_start = 1'b0;
        zSig = 64'd0;
        zExp = 12'd0;
        zSign = 1'b0;
        repeat (2) @(posedge ap_clk);
        #1;
        ap_rst = 1'b0;
        chk("rst idle", 64'(ap_idle), 64'd1);
        chk("rst done", 64'(ap_done), 64'd1);
        chk("rst ready", 64'(ap_ready), 64'd0);
        chk("rst sig", zSig_o, 64'd0);

        foreach (tbl[i]) check_vec($sformatf("tbl%0d", i), tbl[i]);

        // Hold after return to IDLE
        @(posedge ap_clk);
        #1;
        chk("hold sig", zSig_o, tbl[5].e_sig);
        chk("hold exp", 64'(zExp_o), 64'(tbl[5].e_exp));

        // Mid-scan reset abandons the operation
        wait_idle();
        zSig = 64'h1;
        zExp = 12'd100;
        zSign = 1'b1;
        ap_start = 1'b1;
        @(posedge ap_clk);
        #1;
        ap_start = 1'b0;
        repeat (4) @(posedge ap_clk);
        #1;
        ap_rst = 1'b1;
        @(posedge ap_clk);
        #1;
        ap_rst = 1'b0;
        chk("mrst idle", 64'(ap_idle), 64'd1);
        chk("mrst ready", 64'(ap_ready), 64'd0);
        chk("mrst sig", zSig_o, 64'd0);
        chk("mrst exp", 64'(zExp_o), 64'd0);
        chk("mrst sign", 64'(zSign_o), 64'd0);
        seen = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (ap_ready) seen = 1'b1;
            @(posedge ap_clk);
            #1;
        end
        chk("mrst no ready", 64'(seen), 64'd0);
        model(64'h0000_0000_0100_0000, 12'h400, es, ee, el);
        v = '{64'h0000_0000_0100_0000, 12'h400, 1'b0, es, ee, el};
        check_vec("post rst", v);

        // ap_start held high across two requests
        model(64'h0000_00FF_0000_0000, 12'h200, es, ee, el);
        model(64'h0000_0000_0000_0300, 12'h050, es2, ee2, el2);
        wait_idle();
        zSig = 64'h0000_00FF_0000_0000;
        zExp = 12'h200;
        zSign = 1'b1;
        ap_start = 1'b1;
        @(posedge ap_clk);
        #1;
        lat = -1;
        for (int c = 1; c <= 40; c++) begin
            if (c > 1) begin
                @(posedge ap_clk);
                #1;
            end
            if (ap_ready) begin
                lat = c;
                break;
            end
            zSig = {$urandom, $urandom};
            zExp = 12'($urandom);
            zSign = 1'b0;
        end
        chk("b2b lat1", 64'(lat), 64'(el));
        chk("b2b sig1", zSig_o, es);
        chk("b2b exp1", 64'(zExp_o), 64'(ee));
        chk("b2b sign1", 64'(zSign_o), 64'd1);
        zSig = 64'h0000_0000_0000_0300;
        zExp = 12'h050;
        zSign = 1'b0;
        @(posedge ap_clk);
        #1;
        chk("b2b gap done", 64'(ap_done), 64'd0);
        @(posedge ap_clk);
        #1;
        seen = 1'b0;
        lat2 = -1;
        for (int c = 1; c <= 40; c++) begin
            if (c > 1) begin
                @(posedge ap_clk);
                #1;
            end
            if (ap_ready) begin
                lat2 = c;
                break;
            end
            if (zSig_o !== es || zExp_o !== ee) seen = 1'b1;
            zSig = {$urandom, $urandom};
            zExp = 12'($urandom);
            zSign = 1'b1;
        end
        ap_start = 1'b0;
        chk("b2b held", 64'(seen), 64'd0);
        chk("b2b lat2", 64'(lat2), 64'(el2));
        chk("b2b sig2", zSig_o, es2);
        chk("b2b exp2", 64'(zExp_o), 64'(ee2));
        chk("b2b sign2", 64'(zSign_o), 64'd0);

        // Random vectors spread over all leading-zero counts
        for (int i = 0; i < 40; i++) begin
            v.sig  = {$urandom, $urandom} >> $urandom_range(0, 64);
            v.exp  = 12'($urandom);
            v.sign = 1'($urandom);
            model(v.sig, v.exp, v.e_sig, v.e_exp, v.e_lat);
            check_vec($sformatf("rnd%0d", i), v);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
